// File: rtl/decode_unpack.sv
// decode_unpack
//   Bit-stream unpacker for the LZS decode path. Source words (IN_W bits) are
//   fetched from the compressed-source FIFO into a 2*IN_W-bit buffer whose MSB
//   is always the oldest unconsumed stream bit. The token controller sees a
//   PEEK_W-bit look-ahead window, consumes 1..PEEK_W bits per cycle and can
//   skip to the next byte boundary of the stream.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   ce            fetch enable (blocks new requests only)
//   fo_full       downstream FIFO full (blocks new requests only)
//   src_empty     source FIFO empty
//   m_src_getn    active-low source read strobe, one cycle per word
//   fi            source word, valid the cycle after m_src_getn is low
//   stream_data   look-ahead window, stream_data[PEEK_W-1] is the oldest bit
//   stream_valid  window holds at least PEEK_W valid bits
//   stream_width  number of bits consumed by stream_ack
//   stream_ack    consume stream_width bits
//   stream_align  discard bits up to the next byte boundary (after the ack)
//   bit_cnt       bits consumed since reset, wrapping
//   err           sticky protocol-error flag
module decode_unpack #(
  parameter int IN_W      = 64,
  parameter int PEEK_W    = 13,
  parameter int WID_W     = 4,
  parameter int CNT_W     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              fo_full,
  input  logic              src_empty,
  output logic              m_src_getn,
  input  logic [IN_W-1:0]   fi,
  output logic [PEEK_W-1:0] stream_data,
  output logic              stream_valid,
  input  logic [WID_W-1:0]  stream_width,
  input  logic              stream_ack,
  input  logic              stream_align,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              err
);

  localparam int BUF_W = 2 * IN_W;
  localparam int LVL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0] r_buf;
  logic [LVL_W-1:0] r_level;
  logic             r_rd_pend;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_err;

  logic             w_req;
  logic             w_wid_ok;
  logic             w_bad;
  logic [LVL_W-1:0] w_ack_w;
  logic [2:0]       w_pad_sum;
  logic [2:0]       w_pad;
  logic [LVL_W-1:0] w_removed;
  logic [LVL_W-1:0] w_surv;
  logic [IN_W-1:0]  w_word;
  logic [BUF_W-1:0] w_keep;
  logic [BUF_W-1:0] w_buf_next;

  function automatic logic [IN_W-1:0] f_rev(input logic [IN_W-1:0] v);
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W; i++) r[i] = v[IN_W-1-i];
    return r;
  endfunction

  always_comb begin
    // The read strobe is combinational so a request can follow an arrival
    // directly, giving one word every two cycles; gated by rst so it idles
    // high during reset.
    w_req = rst && !r_rd_pend && (r_level <= LVL_W'(IN_W)) && ce && !fo_full && !src_empty;
    m_src_getn   = !w_req;
    stream_valid = (r_level >= LVL_W'(PEEK_W));
    stream_data  = (r_level == '0) ? '0 : r_buf[BUF_W-1 -: PEEK_W];

    w_wid_ok = (stream_width != '0) && (stream_width <= WID_W'(PEEK_W));
    w_bad    = (stream_ack && (!w_wid_ok || !stream_valid)) || (stream_align && !stream_valid);

    // Any protocol violation in a cycle cancels that cycle's consumption.
    w_ack_w   = (stream_ack && !w_bad) ? LVL_W'(stream_width) : '0;
    w_pad_sum = r_bit_cnt[2:0] + w_ack_w[2:0];
    w_pad     = 3'd0 - w_pad_sum;
    w_removed = w_ack_w + ((stream_align && !w_bad) ? LVL_W'(w_pad) : '0);

    // An align asked for before its pad bits have arrived can only drop what
    // is buffered; the level saturates at zero rather than wrapping.
    w_surv = (w_removed > r_level) ? '0 : (r_level - w_removed);

    w_word = MSB_FIRST ? fi : f_rev(fi);

    // Keep only the surviving bits so stale contents below the level never
    // leak into the freshly appended word.
    w_keep     = ~({BUF_W{1'b1}} >> w_surv);
    w_buf_next = ((r_buf << w_removed) & w_keep)
               | (r_rd_pend ? ({w_word, {IN_W{1'b0}}} >> w_surv) : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level   <= '0;
      r_rd_pend <= 1'b0;
      r_bit_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rd_pend <= w_req;
      r_level   <= w_surv + (r_rd_pend ? LVL_W'(IN_W) : '0);
      r_bit_cnt <= r_bit_cnt + CNT_W'(w_removed);
      if (w_bad) r_err <= 1'b1;
    end
  end

  // Buffer contents are qualified by r_level, so they need no reset.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_next;
  end

  assign bit_cnt = r_bit_cnt;
  assign err     = r_err;

endmodule

// File: doc/decode_unpack.md
# decode_unpack

Parametrised bit-stream unpacker for the LZS decode path. It fetches IN_W-bit words from the compressed-source FIFO and presents a PEEK_W-bit look-ahead window to the token controller. The controller consumes 1..PEEK_W bits per cycle and can skip to the next byte boundary, as needed after an LZS end marker. It replaces the fixed 64/13 unpacker and adds configurable widths, selectable bit order, byte alignment, a consumed-bit counter and protocol-error detection.

## Interface
- IN_W, 64, source word width; must be a multiple of 8 and ≥ 2*PEEK_W
- PEEK_W, 13, look-ahead window width; must be ≥ 8
- WID_W, 4, width of stream_width; must be ≥ clog2(PEEK_W+1)
- CNT_W, 32, width of bit_cnt
- MSB_FIRST, 1, 1: fi[IN_W-1] is the oldest bit of a word; 0: fi[0] is the oldest bit
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ce  in  1  fetch enable
- fo_full  in  1  downstream output FIFO full; suppresses fetch
- src_empty  in  1  source FIFO empty
- m_src_getn  out  1  active-low source read strobe, one cycle per word
- fi  in  IN_W  source data, valid the cycle after m_src_getn is low
- stream_data  out  PEEK_W  next PEEK_W stream bits; stream_data[PEEK_W-1] is the oldest
- stream_valid  out  1  window holds ≥ PEEK_W valid bits
- stream_width  in  WID_W  bits to consume with stream_ack
- stream_ack  in  1  consume stream_width bits
- stream_align  in  1  discard bits up to the next byte boundary of the stream
- bit_cnt  out  CNT_W  total bits consumed since reset, modulo 2^CNT_W
- err  out  1  sticky protocol-error flag

## Operation
- Buffer: 2*IN_W-bit shift register plus `level` (0..2*IN_W) counting valid bits, and `rd_pend` (one read in flight).
- Fetch request: assert m_src_getn=0 for one cycle when `!rd_pend && level ≤ IN_W && ce && !fo_full && !src_empty`. rd_pend is set for the next cycle only. fi is captured on that cycle and appended behind the existing bits, word-reversed first if MSB_FIRST=0.
- stream_valid = (level ≥ PEEK_W). stream_data is combinational from the buffer head. It is 0 when level is 0; when 0 < level < PEEK_W the bits below level are don't-care.
- Consume: when stream_ack && stream_valid && 1 ≤ stream_width ≤ PEEK_W, remove stream_width bits and increment bit_cnt by stream_width.
- Align: when stream_align && stream_valid, let pad = (8 − ((bit_cnt + w) mod 8)) mod 8, where w is the accepted ack width that cycle (else 0). Remove w+pad bits and add w+pad to bit_cnt. Ack and align in the same cycle therefore consume first, then pad.
- Error: err is set and held until reset on any of:
  - stream_ack while stream_width = 0
  - stream_ack while stream_width > PEEK_W
  - stream_ack while !stream_valid
  - stream_align while !stream_valid
- An erroneous request changes neither the buffer nor bit_cnt.
- Simultaneous fetch arrival and consume: level_next = level − removed + IN_W. The new word lands directly behind the surviving bits.
- ce low or fo_full high blocks only new requests. An in-flight word is still captured and consumes still proceed.
- bit_cnt wraps modulo 2^CNT_W. Alignment uses bit_cnt[2:0] only.

## Timing
- Reset values (asynchronous, while rst=0):
  - m_src_getn=1, stream_valid=0, stream_data=0, bit_cnt=0, err=0
  - level=0, rd_pend=0
- Reset mid-read: the pending word is dropped; the source FIFO owner handles the lost entry.
- Request to data: m_src_getn low in cycle n → fi sampled at the end of cycle n+1 → level and stream_valid update in cycle n+2.
- First valid window after reset with a non-empty source: stream_valid=1 three cycles after rst deasserts, provided ce=1 and fo_full=0 throughout.
- Consume effect: ack/align in cycle n → new stream_data, stream_valid and bit_cnt visible in cycle n+1.
- Sustained rate: one word per 2 cycles, at most PEEK_W bits consumed per cycle. IN_W ≥ 2*PEEK_W keeps stream_valid continuously high under a non-empty source.
- m_src_getn is never low in two consecutive cycles.

## Test plan
- Reset/fill: release rst with the source holding word 0xF0E1D2C3B4A59687, MSB_FIRST=1, defaults → m_src_getn low exactly once in cycle 1; stream_valid=1 in cycle 3; stream_data=13'h1E1C; bit_cnt=0.
- Variable consume: from the same word, ack widths 9, 8, 13 in consecutive cycles → stream_data steps through the correct shifted windows; bit_cnt = 9, 17, 30; no err.
- Align: at bit_cnt=30, align without ack → bit_cnt=32 and stream_data starts at bit 32 of the stream. At bit_cnt=32, ack 8 with align → bit_cnt=40 (pad 0).
- Word boundary with simultaneous refill: consume 13 per cycle across three words → the concatenated stream has no gaps or duplicates; stream_valid stays 1; m_src_getn never low in consecutive cycles.
- Back-pressure: set fo_full=1 while level ≤ 64 → no m_src_getn pulse; a word already in flight is still appended. Drop fo_full → a request follows within 1 cycle.
- Errors: ack with width 0, ack with width 14, and ack while stream_valid=0 → err rises the next cycle and stays high; bit_cnt and stream_data are unchanged; only rst clears err.
